// File: rtl/ifetch_mem_ctrl.sv
// Instruction fetch responder: direct-mapped one-word-per-line cache in front of a
// byte-wide RAM read port; misses assemble a little-endian word over four byte reads.
module ifetch_mem_ctrl #(
    parameter int ADDR_W = 18,
    parameter int IDX_W  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stl,
    input  logic        mem_busy,
    input  logic        flush,
    input  logic [7:0]  ram_din,
    output logic [31:0] ram_a,
    output logic        ram_wr,
    output logic [1:0]  ok,
    output logic [31:0] dt,
    output logic [7:0]  rom_rn,
    output logic        cache_hit,
    output logic        if_busy
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int LINES = 2 ** IDX_W;

    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3} state_t;

    state_t            state, state_nx;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [31:0]       data_mem [LINES];

    logic [31:0]       addr_q;
    logic [31:0]       ram_a_q;
    logic [7:0]        b0_q, b1_q, b2_q;

    logic [31:0]       a_cur;
    logic [IDX_W-1:0]  idx_cur, idx_q;
    logic [TAG_W-1:0]  tag_cur, tag_q;
    logic              lookup_hit;
    logic              start;
    logic              deliver_hit, deliver_miss;
    logic [1:0]        ok_nx;
    logic              unused_pc_bits;

    // Word-aligned fetch address, confined to the RAM address space.
    assign a_cur          = {{(32-ADDR_W){1'b0}}, pc[ADDR_W-1:2], 2'b00};
    assign idx_cur        = pc[IDX_W+1:2];
    assign tag_cur        = pc[ADDR_W-1:IDX_W+2];
    assign idx_q          = addr_q[IDX_W+1:2];
    assign tag_q          = addr_q[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{pc[31:ADDR_W], pc[1:0]};

    assign lookup_hit = valid_q[idx_cur] && (tag_mem[idx_cur] == tag_cur);
    assign start      = !rst && (state == IDLE) && !stl && !mem_busy && !flush;
    assign ok_nx      = (ok == 2'd3) ? 2'd1 : ok + 2'd1;

    assign ram_wr = 1'b0;
    assign rom_rn = ram_din;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nx     = state;
        ram_a        = ram_a_q;
        if_busy      = 1'b0;
        deliver_hit  = 1'b0;
        deliver_miss = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (lookup_hit) begin
                        deliver_hit = 1'b1;
                    end else begin
                        ram_a    = a_cur;
                        if_busy  = 1'b1;
                        state_nx = RD0;
                    end
                end
            end
            RD0: begin
                ram_a    = addr_q + 32'd1;
                if_busy  = 1'b1;
                state_nx = flush ? IDLE : RD1;
            end
            RD1: begin
                ram_a    = addr_q + 32'd2;
                if_busy  = 1'b1;
                state_nx = flush ? IDLE : RD2;
            end
            RD2: begin
                ram_a    = addr_q + 32'd3;
                if_busy  = 1'b1;
                state_nx = flush ? IDLE : RD3;
            end
            RD3: begin
                ram_a        = addr_q + 32'd3;
                if_busy      = 1'b1;
                deliver_miss = !flush;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset owns the bus outputs so a half-started miss never leaks an address.
        if (rst) begin
            ram_a    = '0;
            if_busy  = 1'b0;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            state     <= IDLE;
            ok        <= 2'd0;
            dt        <= '0;
            cache_hit <= 1'b0;
            ram_a_q   <= '0;
            valid_q   <= '0;
        end else begin
            state   <= state_nx;
            ram_a_q <= ram_a;
            if (deliver_hit) begin
                dt        <= data_mem[idx_cur];
                cache_hit <= 1'b1;
                ok        <= ok_nx;
            end else if (deliver_miss) begin
                // Byte 3 is still on ram_din; the consumer picks it up through rom_rn.
                dt             <= {8'h00, b2_q, b1_q, b0_q};
                cache_hit      <= 1'b0;
                ok             <= ok_nx;
                valid_q[idx_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: tag/data arrays have no reset; the valid bits alone decide whether a line is usable.
        if (start && !lookup_hit) addr_q <= a_cur;
        if (state == RD0) b0_q <= ram_din;
        if (state == RD1) b1_q <= ram_din;
        if (state == RD2) b2_q <= ram_din;
        if (deliver_miss) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= {ram_din, b2_q, b1_q, b0_q};
        end
    end

endmodule

// File: tb/tb_ifetch_mem_ctrl.sv
// Self-checking bench for ifetch_mem_ctrl: table of fetches with a scoreboard of
// expected deliveries, plus hand-written stall, flush and reset-abort sequences.
module tb_ifetch_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stl, mem_busy, flush;
    logic [7:0]  ram_din;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic [1:0]  ok;
    logic [31:0] dt;
    logic [7:0]  rom_rn;
    logic        cache_hit;
    logic        if_busy;

    ifetch_mem_ctrl #(.ADDR_W(18), .IDX_W(7)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stl(stl), .mem_busy(mem_busy), .flush(flush),
        .ram_din(ram_din), .ram_a(ram_a), .ram_wr(ram_wr), .ok(ok), .dt(dt),
        .rom_rn(rom_rn), .cache_hit(cache_hit), .if_busy(if_busy)
    );

    always #5 clk = ~clk;

    // Byte RAM model: read data valid one cycle after the address.
    logic [7:0] mem [1024];
    always @(posedge clk) ram_din <= mem[ram_a[9:0]];

    typedef struct {
        string       name;
        logic [31:0] pc;
        int          flush_at;   // RD index at which flush is raised, -1 for none
        bit          exp_hit;
    } vec_t;

    typedef struct {
        logic [31:0] dt;
        logic        hit;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [9:0] b;
        b = a[9:0];
        return {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
    endfunction

    // Delivery monitor: any change of ok must match the head of the scoreboard.
    initial begin
        logic [1:0] prev_ok;
        logic [1:0] exp_ok;
        exp_t       e;
        prev_ok = 2'd0;
        exp_ok  = 2'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ok  = 2'd0;
                prev_ok = ok;
            end else begin
                if (ok !== prev_ok) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_delivery: ok went %0d -> %0d with nothing expected", prev_ok, ok);
                    end else begin
                        e      = sb.pop_front();
                        exp_ok = (exp_ok == 2'd3) ? 2'd1 : exp_ok + 2'd1;
                        check("ok_seq", {30'd0, ok}, {30'd0, exp_ok});
                        check("deliv_dt", dt, e.dt);
                        check("deliv_hit", {31'd0, cache_hit}, {31'd0, e.hit});
                    end
                end
                prev_ok = ok;
            end
        end
    end

    task automatic do_fetch(input vec_t v);
        logic [31:0] a, w, ra0;
        logic [1:0]  ok0;
        bit          aborted;
        a       = v.pc & 32'h0003_FFFC;
        w       = word_at(a);
        aborted = 1'b0;
        @(negedge clk);
        ra0      = ram_a;
        pc       = v.pc;
        stl      = 1'b0;
        mem_busy = 1'b0;
        flush    = 1'b0;
        #1;
        ok0 = ok;
        check({v.name, "_busy_start"}, {31'd0, if_busy}, {31'd0, !v.exp_hit});
        check({v.name, "_ram_a_start"}, ram_a, v.exp_hit ? ra0 : a);
        if (v.flush_at < 0)
            sb.push_back('{dt: v.exp_hit ? w : {8'h00, w[23:0]}, hit: v.exp_hit});
        if (v.exp_hit) begin
            @(negedge clk);
            stl = 1'b1;
            #1;
            check({v.name, "_hit_latency"}, {31'd0, ok != ok0}, 32'd1);
            check({v.name, "_ram_a_idle"}, ram_a, ra0);
            check({v.name, "_busy_after"}, {31'd0, if_busy}, 32'd0);
        end else begin
            for (int k = 0; k < 4 && !aborted; k++) begin
                @(negedge clk);
                stl   = 1'b1;
                flush = (k == v.flush_at);
                #1;
                check({v.name, "_busy_rd"}, {31'd0, if_busy}, 32'd1);
                check({v.name, "_ok_hold_rd"}, {30'd0, ok}, {30'd0, ok0});
                if (k < 3) check({v.name, "_ram_a_rd"}, ram_a, a + k + 1);
                else       check({v.name, "_rom_rn_rd3"}, {24'd0, rom_rn}, {24'd0, mem[a[9:0] + 10'd3]});
                if (k == v.flush_at) aborted = 1'b1;
            end
            @(negedge clk);
            flush = 1'b0;
            #1;
            check({v.name, "_busy_after"}, {31'd0, if_busy}, 32'd0);
            if (aborted) check({v.name, "_ok_after_flush"}, {30'd0, ok}, {30'd0, ok0});
            else         check({v.name, "_miss_latency"}, {31'd0, ok != ok0}, 32'd1);
        end
    endtask

    vec_t vecs[18];

    initial begin
        logic [31:0] ra_hold;
        vec_t        v;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

        vecs[0]  = '{"cold0",        32'h0000_0000, -1, 1'b0};
        vecs[1]  = '{"hit0",         32'h0000_0000, -1, 1'b1};
        vecs[2]  = '{"hit0_b",       32'h0000_0000, -1, 1'b1};
        vecs[3]  = '{"hit0_c",       32'h0000_0003, -1, 1'b1};
        vecs[4]  = '{"hit0_d",       32'h0000_0000, -1, 1'b1};
        vecs[5]  = '{"hit0_e",       32'h0000_0000, -1, 1'b1};
        vecs[6]  = '{"flush40_rd1",  32'h0000_0040,  1, 1'b0};
        vecs[7]  = '{"miss40",       32'h0000_0040, -1, 1'b0};
        vecs[8]  = '{"hit40_hipc",   32'h0004_0040, -1, 1'b1};
        vecs[9]  = '{"fill200",      32'h0000_0200, -1, 1'b0};
        vecs[10] = '{"conflict0",    32'h0000_0000, -1, 1'b0};
        vecs[11] = '{"rehit0",       32'h0000_0000, -1, 1'b1};
        vecs[12] = '{"flush104_rd3", 32'h0000_0104,  3, 1'b0};
        vecs[13] = '{"miss104",      32'h0000_0104, -1, 1'b0};
        vecs[14] = '{"flush8_rd0",   32'h0000_0008,  0, 1'b0};
        vecs[15] = '{"hit104",       32'h0000_0104, -1, 1'b1};
        vecs[16] = '{"miss3fc",      32'h0000_03FC, -1, 1'b0};
        vecs[17] = '{"hit3fc",       32'h0000_03FC, -1, 1'b1};

        rst = 1'b1; pc = 32'h0; stl = 1'b0; mem_busy = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ok", {30'd0, ok}, 32'd0);
        check("rst_dt", dt, 32'd0);
        check("rst_hit", {31'd0, cache_hit}, 32'd0);
        check("rst_ram_a", ram_a, 32'd0);
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_busy", {31'd0, if_busy}, 32'd0);
        stl = 1'b1;
        rst = 1'b0;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // Hold and bus-busy in IDLE must keep the bus quiet; flush alone blocks one cycle.
        @(negedge clk);
        pc      = 32'h0000_0080;
        ra_hold = ram_a;
        for (int c = 0; c < 7; c++) begin
            stl      = (c < 3);
            mem_busy = (c >= 3 && c < 6);
            flush    = (c == 6);
            #1;
            check("stall_busy", {31'd0, if_busy}, 32'd0);
            check("stall_ram_a", ram_a, ra_hold);
            @(negedge clk);
        end
        v = '{"after_stall80", 32'h0000_0080, -1, 1'b0};
        do_fetch(v);

        // Reset in the middle of a miss: no delivery, no fill, ok back to 0.
        @(negedge clk);
        pc  = 32'h0000_0300;
        stl = 1'b0;
        #1;
        check("rstmid_busy_start", {31'd0, if_busy}, 32'd1);
        @(negedge clk);
        stl = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_ok", {30'd0, ok}, 32'd0);
        check("rstmid_busy", {31'd0, if_busy}, 32'd0);
        repeat (5) @(negedge clk);
        check("rstmid_ok_quiet", {30'd0, ok}, 32'd0);
        v = '{"post_rst300", 32'h0000_0300, -1, 1'b0};
        do_fetch(v);
        v = '{"post_rst0", 32'h0000_0000, -1, 1'b0};
        do_fetch(v);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
